// File: rtl/fir4_pkg.sv
// Shared types and helpers for the fir4_rr_sched block: default sizes, sample/sum types,
// the default-width stage-1 record and the round-robin index wrap helper.
package fir4_pkg;

  localparam int W_DEF   = 16;
  localparam int NCH_DEF = 4;
  localparam int CW_DEF  = $clog2(NCH_DEF);

  typedef logic signed [W_DEF-1:0] samp_t;
  typedef logic signed [W_DEF:0]   part_t;
  typedef logic signed [W_DEF+1:0] sum_t;

  // Stage-1 register layout at the default width; the top re-declares it against its own W/NCH.
  typedef struct packed {
    logic [CW_DEF-1:0] ch;
    part_t             p0;
    part_t             p1;
    logic              valid;
  } s1_t;

  // (base + off) wrapped into 0..n-1, valid for base < n and off <= n.
  function automatic int rr_wrap(input int base, input int off, input int n);
    int s;
    s = base + off;
    return (s >= n) ? s - n : s;
  endfunction

endpackage

// File: rtl/fir4_rr_sched_if.sv
// Sample-source / result-consumer bundle for fir4_rr_sched.
// The flush vector exists only when FIR4_FLUSH_EN is defined.
interface fir4_rr_sched_if
  import fir4_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int NCH = NCH_DEF
);
  localparam int CW = $clog2(NCH);

  logic [NCH-1:0]        in_valid;
  logic [NCH*W-1:0]      in_data;
  logic [NCH-1:0]        in_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [CW-1:0]         out_ch;
  logic signed [W+1:0]   out_s;
`ifdef FIR4_FLUSH_EN
  logic [NCH-1:0]        flush;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_ch, out_s
  );
  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_ch, out_s
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_ch, out_s
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_ch, out_s
  );
`endif

endinterface

// File: rtl/fir4_rr_arb.sv
// NCH-way round-robin arbiter: grants the first request at or above ptr, wrapping to 0.
// Purely combinational; the caller owns the pointer register.
module fir4_rr_arb
  import fir4_pkg::*;
#(
  parameter int  NCH = NCH_DEF,
  localparam int CW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic           en,
  input  logic [CW-1:0]  ptr,
  output logic [NCH-1:0] gnt,
  output logic [CW-1:0]  gnt_idx,
  output logic           gnt_any
);

  logic [CW-1:0] cand;

  always_comb begin
    // NOTE: every output of a combinational block gets a default up front so no path leaves it unassigned (no latch).
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    cand    = '0;
    if (en) begin
      for (int k = 0; k < NCH; k++) begin
        cand = CW'(rr_wrap(int'(ptr), k, NCH));
        if (!gnt_any && req[cand]) begin
          gnt[cand] = 1'b1;
          gnt_idx   = cand;
          gnt_any   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/fir4_rr_sched.sv
// Round-robin time-shared 4-tap moving-sum engine: per-channel tap history, two-stage adder
// pipeline, channel-tagged results. Optional per-channel history flush under FIR4_FLUSH_EN.
module fir4_rr_sched
  import fir4_pkg::*;
#(
  parameter int W   = W_DEF,
  parameter int NCH = NCH_DEF
) (
  input logic             clk,
  input logic             reset,
  fir4_rr_sched_if.slave  bus
);

  localparam int CW = $clog2(NCH);

  typedef struct packed {
    logic                valid;
    logic [CW-1:0]       ch;
    logic signed [W:0]   p0;
    logic signed [W:0]   p1;
  } stage1_t;

  logic                adv;
  logic [CW-1:0]       ptr;
  logic [NCH-1:0]      gnt;
  logic [CW-1:0]       gnt_idx;
  logic                gnt_any;

  logic signed [W-1:0] h1 [NCH];
  logic signed [W-1:0] h2 [NCH];
  logic signed [W-1:0] h3 [NCH];

  logic signed [W-1:0] x;
  logic signed [W-1:0] h1g;
  logic signed [W-1:0] h2g;
  logic signed [W-1:0] h3g;
  logic signed [W:0]   p0_d;
  logic signed [W:0]   p1_d;

  stage1_t             s1;

  // The pipeline only moves when the output slot is empty or being drained.
  assign adv = !bus.out_valid || bus.out_ready;

  // Reset also gates the grant so in_ready stays low while reset is asserted.
  fir4_rr_arb #(.NCH(NCH)) u_arb (
    .req     (bus.in_valid),
    .en      (adv && reset),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign bus.in_ready = gnt;

  assign x    = bus.in_data[int'(gnt_idx)*W +: W];
  assign h1g  = h1[gnt_idx];
  assign h2g  = h2[gnt_idx];
  assign h3g  = h3[gnt_idx];
  assign p0_d = {x[W-1], x} + {h1g[W-1], h1g};
  assign p1_d = {h2g[W-1], h2g} + {h3g[W-1], h3g};

  // A grant is only ever given to an asserted request, so gnt_any is the handshake.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr <= '0;
    end else if (gnt_any) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      ptr <= CW'(rr_wrap(int'(gnt_idx), 1, NCH));
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      // NOTE: the tap histories are real state that must start at zero, so this small array is reset, not left to power-up.
      for (int i = 0; i < NCH; i++) begin
        h1[i] <= '0;
        h2[i] <= '0;
        h3[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (gnt[i]) begin
          h1[i] <= x;
          h2[i] <= h1[i];
          h3[i] <= h2[i];
        end
`ifdef FIR4_FLUSH_EN
        // Flush overrides the shift for the older taps; a same-cycle sample still lands in h1.
        if (bus.flush[i]) begin
          h2[i] <= '0;
          h3[i] <= '0;
          if (!gnt[i]) h1[i] <= '0;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1            <= '0;
      bus.out_valid <= 1'b0;
      bus.out_ch    <= '0;
      bus.out_s     <= '0;
    end else if (adv) begin
      s1.valid <= gnt_any;
      if (gnt_any) begin
        s1.ch <= gnt_idx;
        s1.p0 <= p0_d;
        s1.p1 <= p1_d;
      end
      bus.out_valid <= s1.valid;
      if (s1.valid) begin
        bus.out_ch <= s1.ch;
        bus.out_s  <= {s1.p0[W], s1.p0} + {s1.p1[W], s1.p1};
      end
    end
  end

endmodule

// File: tb/tb_fir4_rr_sched.sv
// Scoreboard bench for fir4_rr_sched: directed per-channel sample streams with hand-computed
// sums queued in expected grant order; an output monitor pops and compares. FIR4_FLUSH_EN adds a flush case.
module tb_fir4_rr_sched;
  import fir4_pkg::*;

  localparam int W   = W_DEF;
  localparam int NCH = NCH_DEF;

  typedef struct {
    int ch;
    int s;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;

  fir4_rr_sched_if #(.W(W), .NCH(NCH)) bus ();

  fir4_rr_sched #(.W(W), .NCH(NCH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  exp_t  sb[$];
  int    hs_cyc[$];
  samp_t samp_q[NCH][$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  bit    chk_lat  = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Output monitor: every accepted result must match the head of the scoreboard.
  always @(negedge clk) begin
    if (reset && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got ch=%0d s=%0d expected none", bus.out_ch, bus.out_s);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("out_ch", int'(bus.out_ch), e.ch);
        check("out_s", int'(bus.out_s), e.s);
        if (chk_lat && hs_cyc.size() > 0) check("latency", cyc - hs_cyc.pop_front(), 2);
      end
    end
  end

  function automatic int pending();
    int n;
    n = 0;
    for (int i = 0; i < NCH; i++) n += samp_q[i].size();
    return n;
  endfunction

  task automatic expect_res(input int ch, input int s);
    exp_t e;
    e.ch = ch;
    e.s  = s;
    sb.push_back(e);
  endtask

  // Presents every channel's queued samples, holding each until it is accepted.
  task automatic run(input string name, input int budget);
    int n;
    n = 0;
    while (pending() > 0 && n < budget) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < NCH; i++) begin
        bus.in_valid[i] = (samp_q[i].size() > 0);
        if (samp_q[i].size() > 0) bus.in_data[i*W +: W] = samp_q[i][0];
      end
      @(negedge clk);
      check({name, "_ready_onehot0"}, int'($onehot0(bus.in_ready)), 1);
      for (int i = 0; i < NCH; i++) begin
        if (bus.in_ready[i] && bus.in_valid[i]) begin
          void'(samp_q[i].pop_front());
          if (chk_lat) hs_cyc.push_back(cyc);
        end
      end
      n++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = '0;
    check({name, "_all_sent"}, pending(), 0);
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drained"}, sb.size(), 0);
  endtask

  task automatic apply_reset();
    @(posedge clk);
    #1;
    reset         = 1'b0;
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
`ifdef FIR4_FLUSH_EN
    bus.flush     = '0;
`endif
    sb.delete();
    hs_cyc.delete();
    for (int i = 0; i < NCH; i++) samp_q[i].delete();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int    cap_s;
    int    cap_ch;
    bus.in_valid  = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
`ifdef FIR4_FLUSH_EN
    bus.flush     = '0;
`endif

    // 1: requests during reset must not be granted; idle after release.
    bus.in_valid = '1;
    repeat (2) @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 0);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_out_s", int'(bus.out_s), 0);
    bus.in_valid = '0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_in_ready", int'(bus.in_ready), 0);
      check("idle_out_valid", int'(bus.out_valid), 0);
      check("idle_out_s", int'(bus.out_s), 0);
    end

    // 2: ch0 alone, 1..5 back-to-back, two-cycle latency.
    apply_reset();
    chk_lat = 1'b1;
    for (int v = 1; v <= 5; v++) samp_q[0].push_back(samp_t'(v));
    expect_res(0, 1); expect_res(0, 3); expect_res(0, 6); expect_res(0, 10); expect_res(0, 14);
    run("t2", 20);
    drain("t2", 10);
    chk_lat = 1'b0;

    // 3: all channels continuously, data i+1; grants in order 0,1,2,3 each round.
    apply_reset();
    for (int r = 1; r <= 5; r++) begin
      for (int i = 0; i < NCH; i++) begin
        samp_q[i].push_back(samp_t'(i + 1));
        expect_res(i, (i + 1) * ((r < 4) ? r : 4));
      end
    end
    run("t3", 60);
    drain("t3", 10);

    // 4: backpressure for 5 cycles in the middle of a ch1 stream.
    apply_reset();
    for (int v = 1; v <= 8; v++) samp_q[1].push_back(samp_t'(10 * v));
    expect_res(1, 10);  expect_res(1, 30);  expect_res(1, 60);  expect_res(1, 100);
    expect_res(1, 140); expect_res(1, 180); expect_res(1, 220); expect_res(1, 260);
    fork
      run("t4", 60);
      begin
        repeat (4) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        check("stall_out_valid", int'(bus.out_valid), 1);
        check("stall_in_ready", int'(bus.in_ready), 0);
        cap_s  = int'(bus.out_s);
        cap_ch = int'(bus.out_ch);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("stall_hold_valid", int'(bus.out_valid), 1);
          check("stall_hold_s", int'(bus.out_s), cap_s);
          check("stall_hold_ch", int'(bus.out_ch), cap_ch);
          check("stall_in_ready", int'(bus.in_ready), 0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain("t4", 10);

    // 5: full-scale positive then negative samples on ch2, no wrap in the W+2-bit sum.
    apply_reset();
    for (int k = 0; k < 4; k++) samp_q[2].push_back(samp_t'(16'h7FFF));
    for (int k = 0; k < 4; k++) samp_q[2].push_back(samp_t'(16'h8000));
    expect_res(2, 32767);  expect_res(2, 65534); expect_res(2, 98301);  expect_res(2, 131068);
    expect_res(2, 65533);  expect_res(2, -2);    expect_res(2, -65537); expect_res(2, -131072);
    run("t5", 30);
    drain("t5", 10);

    // 6: reset with two results in flight, then history must be clear.
    apply_reset();
    bus.out_ready = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid[0] = 1'b1;
    bus.in_data[0 +: W] = samp_t'(1);
    @(posedge clk);
    #1;
    bus.in_data[0 +: W] = samp_t'(2);
    @(posedge clk);
    #1;
    bus.in_valid = '0;
    @(negedge clk);
    check("inflight_out_valid", int'(bus.out_valid), 1);
    check("inflight_out_s", int'(bus.out_s), 1);
    #2;
    reset = 1'b0;
    #1;
    check("midrst_out_valid", int'(bus.out_valid), 0);
    check("midrst_out_s", int'(bus.out_s), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.out_ready = 1'b1;
    samp_q[0].push_back(samp_t'(7));
    expect_res(0, 7);
    run("t6", 10);
    drain("t6", 10);
    repeat (3) @(negedge clk);
    check("t6_no_stale", int'(bus.out_valid), 0);

`ifdef FIR4_FLUSH_EN
    // Flush ch1 history after 1,2,3; the next sample sums alone.
    apply_reset();
    for (int v = 1; v <= 3; v++) samp_q[1].push_back(samp_t'(v));
    expect_res(1, 1); expect_res(1, 3); expect_res(1, 6);
    run("tf_a", 20);
    drain("tf_a", 10);
    @(posedge clk);
    #1;
    bus.flush[1] = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = '0;
    samp_q[1].push_back(samp_t'(4));
    expect_res(1, 4);
    run("tf_b", 10);
    drain("tf_b", 10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
